// File: rtl/fpu_exc_pkg.sv
// Shared encodings for the FPU exception pipeline: op select, case codes, operand classes.
package fpu_exc_pkg;

  localparam int unsigned OP_W   = 2;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned CLS_W  = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB  = 2'b01;
  localparam logic [OP_W-1:0] OP_MUL  = 2'b10;
  localparam logic [OP_W-1:0] OP_RSVD = 2'b11;

  typedef enum logic [CODE_W-1:0] {
    EXC_NONE    = 3'd0,
    EXC_NAN     = 3'd1,
    EXC_COPY_A  = 3'd2,
    EXC_COPY_B  = 3'd3,
    EXC_INF     = 3'd4,
    EXC_ZERO    = 3'd5,
    EXC_CANCEL  = 3'd6,
    EXC_INVALID = 3'd7
  } exc_code_e;

  typedef enum logic [CLS_W-1:0] {
    CLS_ZERO    = 3'd0,
    CLS_SUBNORM = 3'd1,
    CLS_NORMAL  = 3'd2,
    CLS_INF     = 3'd3,
    CLS_QNAN    = 3'd4,
    CLS_SNAN    = 3'd5
  } fp_class_e;

  // Either NaN flavour.
  function automatic logic is_nan(input fp_class_e c);
    return (c == CLS_QNAN) || (c == CLS_SNAN);
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Classifies one operand magnitude (exponent + mantissa, sign excluded).
module fp_classify
  import fpu_exc_pkg::*;
#(
  parameter int unsigned EXP_BITS  = 8,
  parameter int unsigned MANT_BITS = 23
) (
  input  logic [EXP_BITS+MANT_BITS-1:0] mag,
  output fp_class_e                     cls_c
);

  logic [EXP_BITS-1:0]  exp_f;
  logic [MANT_BITS-1:0] mant_f;

  assign exp_f  = mag[EXP_BITS+MANT_BITS-1:MANT_BITS];
  assign mant_f = mag[MANT_BITS-1:0];

  // Subnormals count as finite nonzero; NaN quietness comes from the mantissa MSB.
  always_comb begin
    cls_c = CLS_NORMAL;
    if (exp_f == '0) begin
      cls_c = (mant_f == '0) ? CLS_ZERO : CLS_SUBNORM;
    end else if (&exp_f) begin
      if (mant_f == '0)               cls_c = CLS_INF;
      else if (mant_f[MANT_BITS-1])   cls_c = CLS_QNAN;
      else                            cls_c = CLS_SNAN;
    end
  end

endmodule

// File: rtl/fpu_exception_pipe.sv
// Two-stage pipe (classify, resolve) that detects IEEE-754 special-case results
// for ADD/SUB/MUL and keeps a sticky invalid flag plus a saturating special count.
module fpu_exception_pipe
  import fpu_exc_pkg::*;
#(
  parameter int unsigned EXP_BITS  = 8,
  parameter int unsigned MANT_BITS = 23,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_BITS  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [OP_W-1:0]     op_sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                special,
  output logic [CODE_W-1:0]   exception_flag,
  output logic [WIDTH-1:0]    result,
  output logic                nv_flag,
  input  logic                flag_clr,
  output logic [CNT_BITS-1:0] exc_count
);

  localparam int unsigned MAG_W = EXP_BITS + MANT_BITS;
  localparam logic [WIDTH-1:0] CANON_NAN =
    {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};

  if (WIDTH != 1 + EXP_BITS + MANT_BITS) begin : g_bad_width
    $error("fpu_exception_pipe: WIDTH must equal 1+EXP_BITS+MANT_BITS");
  end

  fp_class_e cls_a_c, cls_b_c;

  fp_classify #(.EXP_BITS(EXP_BITS), .MANT_BITS(MANT_BITS)) u_cls_a (
    .mag   (a[MAG_W-1:0]),
    .cls_c (cls_a_c)
  );

  fp_classify #(.EXP_BITS(EXP_BITS), .MANT_BITS(MANT_BITS)) u_cls_b (
    .mag   (b[MAG_W-1:0]),
    .cls_c (cls_b_c)
  );

  // Stage 1 (classify) state
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [OP_W-1:0]  s1_op;
  fp_class_e        s1_cls_a, s1_cls_b;

  // Stage 2 (resolve) state
  logic             s2_valid;
  exc_code_e        s2_code;
  logic [WIDTH-1:0] s2_result;
  logic             s2_special;
  logic             s2_invalid;

  logic                nv_q;
  logic [CNT_BITS-1:0] cnt_q;

  logic advance_c;
  logic accept_c;

  // Both stages move together whenever the output slot is free or being drained.
  assign advance_c = !s2_valid || out_ready;
  assign accept_c  = s2_valid && out_ready;
  assign in_ready  = advance_c;

  // Stage 1: capture operands and their classes.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
      s1_cls_a <= CLS_ZERO;
      s1_cls_b <= CLS_ZERO;
    end else if (advance_c) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a     <= a;
        s1_b     <= b;
        s1_op    <= op_sel;
        s1_cls_a <= cls_a_c;
        s1_cls_b <= cls_b_c;
      end
    end
  end

  exc_code_e        res_code_c;
  logic [WIDTH-1:0] res_val_c;
  logic             res_inv_c;

  logic             a_sign_c, b_eff_c, mul_sign_c, any_nan_c, any_snan_c;
  logic [MAG_W-1:0] a_mag_c, b_mag_c;

  // Resolve: first-match priority of the special cases for the staged op.
  always_comb begin
    res_code_c = EXC_NONE;
    res_val_c  = '0;
    res_inv_c  = 1'b0;

    a_sign_c   = s1_a[WIDTH-1];
    b_eff_c    = s1_b[WIDTH-1] ^ (s1_op == OP_SUB);
    mul_sign_c = s1_a[WIDTH-1] ^ s1_b[WIDTH-1];
    a_mag_c    = s1_a[MAG_W-1:0];
    b_mag_c    = s1_b[MAG_W-1:0];
    any_nan_c  = is_nan(s1_cls_a) || is_nan(s1_cls_b);
    any_snan_c = (s1_cls_a == CLS_SNAN) || (s1_cls_b == CLS_SNAN);

    if (s1_op == OP_ADD || s1_op == OP_SUB) begin
      if (any_nan_c) begin
        res_code_c = EXC_NAN;
        res_val_c  = CANON_NAN;
      end else if (s1_cls_a == CLS_INF && s1_cls_b == CLS_INF && a_sign_c != b_eff_c) begin
        res_code_c = EXC_INVALID;
        res_val_c  = CANON_NAN;
      end else if (s1_cls_a == CLS_INF) begin
        res_code_c = EXC_INF;
        res_val_c  = s1_a;
      end else if (s1_cls_b == CLS_INF) begin
        res_code_c = EXC_INF;
        res_val_c  = {b_eff_c, b_mag_c};
      end else if (s1_cls_a == CLS_ZERO && s1_cls_b == CLS_ZERO) begin
        res_code_c = EXC_ZERO;
        res_val_c  = {a_sign_c & b_eff_c, {MAG_W{1'b0}}};
      end else if (s1_cls_a == CLS_ZERO) begin
        res_code_c = EXC_COPY_B;
        res_val_c  = {b_eff_c, b_mag_c};
      end else if (s1_cls_b == CLS_ZERO) begin
        res_code_c = EXC_COPY_A;
        res_val_c  = s1_a;
      end else if (a_mag_c == b_mag_c && a_sign_c != b_eff_c) begin
        res_code_c = EXC_CANCEL;
        res_val_c  = '0;
      end
    end else if (s1_op == OP_MUL) begin
      if (any_nan_c) begin
        res_code_c = EXC_NAN;
        res_val_c  = CANON_NAN;
      end else if ((s1_cls_a == CLS_INF && s1_cls_b == CLS_ZERO) ||
                   (s1_cls_a == CLS_ZERO && s1_cls_b == CLS_INF)) begin
        res_code_c = EXC_INVALID;
        res_val_c  = CANON_NAN;
      end else if (s1_cls_a == CLS_INF || s1_cls_b == CLS_INF) begin
        res_code_c = EXC_INF;
        res_val_c  = {mul_sign_c, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
      end else if (s1_cls_a == CLS_ZERO || s1_cls_b == CLS_ZERO) begin
        res_code_c = EXC_ZERO;
        res_val_c  = {mul_sign_c, {MAG_W{1'b0}}};
      end
    end

    res_inv_c = (res_code_c == EXC_INVALID) || (res_code_c == EXC_NAN && any_snan_c);
  end

  // Stage 2: register the resolved case; bubbles leave an all-zero payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_code    <= EXC_NONE;
      s2_result  <= '0;
      s2_special <= 1'b0;
      s2_invalid <= 1'b0;
    end else if (advance_c) begin
      s2_valid   <= s1_valid;
      s2_code    <= s1_valid ? res_code_c : EXC_NONE;
      s2_result  <= s1_valid ? res_val_c : '0;
      s2_special <= s1_valid && (res_code_c != EXC_NONE);
      s2_invalid <= s1_valid && res_inv_c;
    end
  end

  // Sticky invalid flag and saturating special count; a set/increment wins over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      nv_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (accept_c && s2_invalid) nv_q <= 1'b1;
      else if (flag_clr)          nv_q <= 1'b0;

      if (flag_clr)
        cnt_q <= (accept_c && s2_special) ? CNT_BITS'(1) : '0;
      else if (accept_c && s2_special && !(&cnt_q))
        cnt_q <= cnt_q + CNT_BITS'(1);
    end
  end

  assign out_valid      = s2_valid;
  assign special        = s2_special;
  assign exception_flag = s2_code;
  assign result         = s2_result;
  assign nv_flag        = nv_q;
  assign exc_count      = cnt_q;

endmodule

// File: tb/tb_fpu_exception_pipe.sv
// Randomized + directed bench for fpu_exception_pipe with a behavioural reference model.
module tb_fpu_exception_pipe;

  localparam int unsigned CB    = 2;
  localparam int unsigned CMAX  = (1 << CB) - 1;
  localparam logic [31:0] CNAN  = 32'h7FC0_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [31:0]   a, b, result;
  logic [1:0]    op_sel;
  logic          special, nv_flag, flag_clr;
  logic [2:0]    exception_flag;
  logic [CB-1:0] exc_count;

  fpu_exception_pipe #(
    .EXP_BITS(8), .MANT_BITS(23), .WIDTH(32), .CNT_BITS(CB)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_sel(op_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .special(special), .exception_flag(exception_flag), .result(result),
    .nv_flag(nv_flag), .flag_clr(flag_clr), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  code;
    logic [31:0] res;
    logic        inv;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_out    = 0;
  logic        m_nv;
  int unsigned m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Field views of a binary32 value, by plain arithmetic.
  function automatic int unsigned f_exp(input logic [31:0] x);
    return (x >> 23) & 32'hFF;
  endfunction
  function automatic int unsigned f_man(input logic [31:0] x);
    return x & 32'h7F_FFFF;
  endfunction
  function automatic bit f_nan(input logic [31:0] x);
    return f_exp(x) == 255 && f_man(x) != 0;
  endfunction
  function automatic bit f_snan(input logic [31:0] x);
    return f_nan(x) && f_man(x) < 32'h40_0000;
  endfunction
  function automatic bit f_inf(input logic [31:0] x);
    return f_exp(x) == 255 && f_man(x) == 0;
  endfunction
  function automatic bit f_zero(input logic [31:0] x);
    return (x & 32'h7FFF_FFFF) == 0;
  endfunction

  function automatic exp_t mk(input int code, input logic [31:0] res, input bit inv);
    exp_t r;
    r.code = 3'(code);
    r.res  = res;
    r.inv  = inv;
    return r;
  endfunction

  // Reference: special-case table for one operation.
  function automatic exp_t ref_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op);
    logic [31:0] mx, my;
    bit          sx, sy, sm, snan;
    mx   = x & 32'h7FFF_FFFF;
    my   = y & 32'h7FFF_FFFF;
    sx   = x[31];
    sy   = y[31] ^ (op == 2'd1);
    sm   = x[31] ^ y[31];
    snan = f_snan(x) || f_snan(y);
    if (op == 2'd0 || op == 2'd1) begin
      if (f_nan(x) || f_nan(y))                 return mk(1, CNAN, snan);
      if (f_inf(x) && f_inf(y) && sx != sy)     return mk(7, CNAN, 1'b1);
      if (f_inf(x))                             return mk(4, x, 1'b0);
      if (f_inf(y))                             return mk(4, {sy, my[30:0]}, 1'b0);
      if (f_zero(x) && f_zero(y))               return mk(5, {sx & sy, 31'h0}, 1'b0);
      if (f_zero(x))                            return mk(3, {sy, my[30:0]}, 1'b0);
      if (f_zero(y))                            return mk(2, x, 1'b0);
      if (mx == my && sx != sy)                 return mk(6, 32'h0, 1'b0);
    end else if (op == 2'd2) begin
      if (f_nan(x) || f_nan(y))                 return mk(1, CNAN, snan);
      if ((f_inf(x) && f_zero(y)) || (f_zero(x) && f_inf(y)))
                                                return mk(7, CNAN, 1'b1);
      if (f_inf(x) || f_inf(y))                 return mk(4, sm ? 32'hFF80_0000 : 32'h7F80_0000, 1'b0);
      if (f_zero(x) || f_zero(y))               return mk(5, sm ? 32'h8000_0000 : 32'h0, 1'b0);
    end
    return mk(0, 32'h0, 1'b0);
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] s;
    s = 32'($urandom_range(0, 1)) << 31;
    case ($urandom_range(0, 7))
      0:       return s;
      1:       return s | (($urandom & 32'h7F_FFFF) | 32'h1);
      2, 3:    return s | (32'($urandom_range(1, 254)) << 23) | ($urandom & 32'h7F_FFFF);
      4:       return s | 32'h7F80_0000;
      5:       return s | 32'h7FC0_0000 | ($urandom & 32'h3F_FFFF);
      6:       return s | 32'h7F80_0000 | (($urandom & 32'h3F_FFFF) | 32'h1);
      default: return s | 32'h3F80_0000;
    endcase
  endfunction

  // One clock: drive at negedge, then check outputs and advance the model.
  task automatic cycle(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [1:0] iop, input logic ordy, input logic fclr);
    exp_t h;
    bit   acc;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    op_sel    = iop;
    out_ready = ordy;
    flag_clr  = fclr;
    #1;
    check_eq("nv_flag", 32'(nv_flag), 32'(m_nv));
    check_eq("exc_count", 32'(exc_count), m_cnt);
    acc = 0;
    h   = mk(0, 32'h0, 1'b0);
    if (sb.size() == 0) begin
      check_eq("out_valid_idle", 32'(out_valid), 32'h0);
    end else if (out_valid) begin
      h = sb[0];
      check_eq("code", 32'(exception_flag), 32'(h.code));
      check_eq("result", result, h.res);
      check_eq("special", 32'(special), 32'(h.code != 3'd0));
      if (ordy) begin
        acc = 1;
        void'(sb.pop_front());
        n_out++;
      end
    end
    if (acc && h.inv) m_nv = 1'b1;
    else if (fclr)    m_nv = 1'b0;
    if (fclr)
      m_cnt = (acc && h.code != 3'd0) ? 1 : 0;
    else if (acc && h.code != 3'd0 && m_cnt != CMAX)
      m_cnt = m_cnt + 1;
    if (iv && in_ready) sb.push_back(ref_op(ia, ib, iop));
  endtask

  task automatic idle(input logic fclr);
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, fclr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flag_clr  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_nv  = 1'b0;
    m_cnt = 0;
  endtask

  // Single op with no backpressure; expects out_valid exactly two cycles later.
  task automatic run_one(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [1:0] op, input int code, input logic [31:0] res);
    cycle(1'b1, x, y, op, 1'b1, 1'b0);
    idle(1'b0);
    check_eq({tag, "_lat1"}, 32'(out_valid), 32'h0);
    idle(1'b0);
    check_eq({tag, "_lat2"}, 32'(out_valid), 32'h1);
    check_eq({tag, "_code"}, 32'(exception_flag), 32'(code));
    check_eq({tag, "_res"}, result, res);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int out0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
    a = '0; b = '0; op_sel = '0;
    m_nv = 1'b0; m_cnt = 0;

    do_reset();
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("rst_in_ready", 32'(in_ready), 32'h1);
    check_eq("rst_code", 32'(exception_flag), 32'h0);
    check_eq("rst_result", result, 32'h0);
    check_eq("rst_special", 32'(special), 32'h0);
    check_eq("rst_nv", 32'(nv_flag), 32'h0);
    check_eq("rst_cnt", 32'(exc_count), 32'h0);

    // inf - inf
    run_one("sub_inf", 32'h7F80_0000, 32'h7F80_0000, 2'd1, 7, CNAN);
    idle(1'b0);
    check_eq("sub_inf_nv", 32'(nv_flag), 32'h1);
    check_eq("sub_inf_cnt", 32'(exc_count), 32'h1);

    // sNaN operand, then clear
    do_reset();
    run_one("snan", 32'h7F80_0001, 32'h3F80_0000, 2'd0, 1, CNAN);
    idle(1'b0);
    check_eq("snan_nv", 32'(nv_flag), 32'h1);
    idle(1'b1);
    idle(1'b0);
    check_eq("snan_nv_clr", 32'(nv_flag), 32'h0);

    run_one("mul_0inf", 32'h8000_0000, 32'h7F80_0000, 2'd2, 7, CNAN);
    run_one("mul_inf", 32'hC000_0000, 32'h7F80_0000, 2'd2, 4, 32'hFF80_0000);
    run_one("cancel", 32'h3F80_0000, 32'h3F80_0000, 2'd1, 6, 32'h0);
    run_one("negzero", 32'h8000_0000, 32'h8000_0000, 2'd0, 5, 32'h8000_0000);
    run_one("rsvd", 32'h7F80_0000, 32'h0, 2'd3, 0, 32'h0);

    // Backpressure: three stalled cycles with a full pipe
    do_reset();
    out0 = n_out;
    cycle(1'b1, 32'h0, 32'h3F80_0000, 2'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'h7F80_0000, 32'h0, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h4000_0000, 32'hC000_0000, 2'd0, 1'b0, 1'b0);
      check_eq("stall_in_ready", 32'(in_ready), 32'h0);
      check_eq("stall_out_valid", 32'(out_valid), 32'h1);
    end
    cycle(1'b1, 32'h4000_0000, 32'hC000_0000, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);
    check_eq("stall_drained", 32'(sb.size()), 32'h0);
    check_eq("stall_count", 32'(n_out - out0), 32'h3);

    // Reset with ops in flight
    do_reset();
    cycle(1'b1, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'h7F80_0000, 32'h0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check_eq("midrst_pre", 32'(out_valid), 32'h1);
    @(negedge clk);
    #1;
    check_eq("midrst_post", 32'(out_valid), 32'h0);
    rst = 1'b0;
    sb.delete();
    m_nv = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < 4; i++) idle(1'b0);

    // Counter saturation at 3, then clear coinciding with a special accept
    do_reset();
    for (int i = 0; i < 4; i++)
      run_one("sat", 32'h0, 32'h0, 2'd0, 5, 32'h0);
    idle(1'b0);
    check_eq("sat_cnt", 32'(exc_count), 32'h3);
    cycle(1'b1, 32'h0, 32'h3F80_0000, 2'd2, 1'b1, 1'b0);
    idle(1'b0);
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b1);
    check_eq("clr_acc_valid", 32'(out_valid), 32'h1);
    idle(1'b0);
    check_eq("clr_acc_cnt", 32'(exc_count), 32'h1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] x, y;
      x = rand_operand();
      y = ($urandom_range(0, 7) == 0) ? (x ^ 32'h8000_0000) : rand_operand();
      cycle(1'($urandom_range(0, 9) < 7), x, y, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
    end
    for (int i = 0; i < 6; i++) idle(1'b0);
    check_eq("rand_drained", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
